ffn_result_drain: RTL and testbench



---
 rtl/ffn_pkg.sv | 23 ++
 rtl/ffn_vec_fifo.sv | 66 ++++++
 rtl/ffn_result_drain.sv | 118 +++++++++++
 tb/tb_ffn_result_drain.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ffn_pkg.sv
// ==========================================================================
// Module      : ffn_pkg
// Description : Shared defaults and types for the FFN result drain.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

package ffn_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int NEURON_NUM_DEF = 4;
  localparam int DEPTH_DEF      = 4;

  typedef logic [$clog2(NEURON_NUM_DEF)-1:0] lane_idx_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_e;

endpackage : ffn_pkg

`default_nettype wire

// File: rtl/ffn_vec_fifo.sv
// ==========================================================================
// Module      : ffn_vec_fifo
// Description : Synchronous DEPTH x WIDTH vector FIFO; a push is accepted
//               when full only if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module ffn_vec_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : ffn_vec_fifo

`default_nettype wire

// File: rtl/ffn_result_drain.sv
// ==========================================================================
// Module      : ffn_result_drain
// Description : Captures FFN result vectors on done rising edge, buffers
//               them and streams them lane by lane (lane 0 = MSB slice).
//               Optional macro FFN_DRAIN_RELU_EN applies ReLU per lane.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module ffn_result_drain
  import ffn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NEURON_NUM = NEURON_NUM_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [DATA_WIDTH*NEURON_NUM-1:0] acc_i,
  input  logic                           done_i,
  output logic [DATA_WIDTH-1:0]          out_data_o,
  output logic [$clog2(NEURON_NUM)-1:0]  out_lane_o,
  output logic                           out_last_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic                           overflow_o,
  output logic                           busy_o
);

  localparam int VW = DATA_WIDTH * NEURON_NUM;
  localparam int LW = $clog2(NEURON_NUM);
  localparam int CW = $clog2(DEPTH) + 1;

  drain_state_e      r_state;
  drain_state_e      w_state_nxt;
  logic              r_done_q;
  logic              r_overflow;
  logic [LW-1:0]     r_lane;
  logic              w_capture;
  logic              w_xfer;
  logic              w_last;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [VW-1:0]     w_head;
  logic [CW-1:0]     w_count;
  logic [DATA_WIDTH-1:0] w_lane_raw;
  logic [DATA_WIDTH-1:0] w_lane_out;

  assign w_capture = done_i & ~r_done_q;
  assign w_last    = (r_lane == LW'(NEURON_NUM - 1));
  assign w_xfer    = out_valid_o & out_ready_i;
  assign w_pop     = w_xfer & w_last;

  ffn_vec_fifo #(
    .WIDTH (VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_capture),
    .i_pop   (w_pop),
    .i_wdata (acc_i),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_lane_raw = w_head[VW-1 - int'(r_lane)*DATA_WIDTH -: DATA_WIDTH];

`ifdef FFN_DRAIN_RELU_EN
  assign w_lane_out = w_lane_raw[DATA_WIDTH-1] ? '0 : w_lane_raw;
`else
  assign w_lane_out = w_lane_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_done_q   <= 1'b0;
      r_overflow <= 1'b0;
      r_lane     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_q <= done_i;
      if (w_capture & w_full & ~w_pop) r_overflow <= 1'b1;
      if (w_xfer) r_lane <= w_last ? '0 : r_lane + LW'(1);
    end
  end

  // STREAM tracks count != 0, looking one edge ahead so a capture into an
  // empty FIFO is presented on the very next cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_pop && (w_count == CW'(1)) && !w_capture) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign out_valid_o = (r_state == ST_STREAM);
  assign out_data_o  = out_valid_o ? w_lane_out : '0;
  assign out_lane_o  = r_lane;
  assign out_last_o  = out_valid_o & w_last;
  assign count_o     = w_count;
  assign overflow_o  = r_overflow;
  assign busy_o      = ~w_empty;

endmodule : ffn_result_drain

`default_nettype wire

// File: tb/tb_ffn_result_drain.sv
// ==========================================================================
// Module      : tb_ffn_result_drain
// Description : Directed, table-driven bench for ffn_result_drain.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_ffn_result_drain;

  logic        clk;
  logic        rstn;
  logic [63:0] acc_i;
  logic        done_i;
  logic [15:0] out_data_o;
  logic [1:0]  out_lane_o;
  logic        out_last_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [2:0]  count_o;
  logic        overflow_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  ffn_result_drain #(
    .DATA_WIDTH (16),
    .NEURON_NUM (4),
    .DEPTH      (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .acc_i       (acc_i),
    .done_i      (done_i),
    .out_data_o  (out_data_o),
    .out_lane_o  (out_lane_o),
    .out_last_o  (out_last_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] acc;
    logic [63:0] exp_raw;
    logic [63:0] exp_relu;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [63:0] expv(input int i);
`ifdef FFN_DRAIN_RELU_EN
    return tbl[i].exp_relu;
`else
    return tbl[i].exp_raw;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One rising edge on done_i followed by a low cycle so the next call
  // is a fresh edge.
  task automatic capture(input int i);
    acc_i  = tbl[i].acc;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
  endtask

  task automatic drain_vec(input int i, input string nm);
    logic [63:0] e;
    e = expv(i);
    out_ready_i = 1'b1;
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("%s valid l%0d", nm, l), 64'(out_valid_o), 64'd1);
      chk($sformatf("%s lane l%0d", nm, l), 64'(out_lane_o), 64'(l));
      chk($sformatf("%s data l%0d", nm, l), 64'(out_data_o), 64'(e[63-16*l -: 16]));
      chk($sformatf("%s last l%0d", nm, l), 64'(out_last_o), 64'(l == 3));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] e;
    int          exp_lane;
    logic        pat [7];

    tbl[0] = '{64'h0001_0002_FFFE_0004, 64'h0001_0002_FFFE_0004, 64'h0001_0002_0000_0004};
    tbl[1] = '{64'h8000_7FFF_0000_FFFF, 64'h8000_7FFF_0000_FFFF, 64'h0000_7FFF_0000_0000};
    tbl[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_0000_0000};
    tbl[3] = '{64'hAAAA_5555_0F0F_F0F0, 64'hAAAA_5555_0F0F_F0F0, 64'h0000_5555_0F0F_0000};
    tbl[4] = '{64'h7FFF_8001_0100_FFFF, 64'h7FFF_8001_0100_FFFF, 64'h7FFF_0000_0100_0000};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    rstn = 1'b0; done_i = 1'b0; acc_i = '0; out_ready_i = 1'b0;
    tick(); tick();
    chk("rst valid", 64'(out_valid_o), 64'd0);
    chk("rst data",  64'(out_data_o),  64'd0);
    chk("rst lane",  64'(out_lane_o),  64'd0);
    chk("rst last",  64'(out_last_o),  64'd0);
    chk("rst count", 64'(count_o),     64'd0);
    chk("rst busy",  64'(busy_o),      64'd0);
    chk("rst ovf",   64'(overflow_o),  64'd0);
    rstn = 1'b1;
    tick();

    // Table-driven single captures with ready held high.
    for (int i = 0; i < 5; i++) begin
      out_ready_i = 1'b1;
      capture(i);
      chk($sformatf("single%0d count", i), 64'(count_o), 64'd1);
      drain_vec(i, $sformatf("single%0d", i));
      chk($sformatf("single%0d idle", i), 64'(out_valid_o), 64'd0);
      chk($sformatf("single%0d empty", i), 64'(count_o), 64'd0);
      chk($sformatf("single%0d busy", i), 64'(busy_o), 64'd0);
    end

    // Backpressure: ready 1,0,0,1,1,...
    out_ready_i = 1'b0;
    capture(2);
    e = expv(2);
    exp_lane = 0;
    for (int c = 0; c < 12 && exp_lane < 4; c++) begin
      out_ready_i = (c < 7) ? pat[c] : 1'b1;
      chk($sformatf("bp valid c%0d", c), 64'(out_valid_o), 64'd1);
      chk($sformatf("bp lane c%0d", c), 64'(out_lane_o), 64'(exp_lane));
      chk($sformatf("bp data c%0d", c), 64'(out_data_o), 64'(e[63-16*exp_lane -: 16]));
      tick();
      if (out_ready_i) exp_lane++;
    end
    chk("bp done", 64'(out_valid_o), 64'd0);

    // done_i held high for 10 cycles captures once.
    out_ready_i = 1'b0;
    acc_i  = tbl[3].acc;
    done_i = 1'b1;
    repeat (10) tick();
    chk("hold count", 64'(count_o), 64'd1);
    done_i = 1'b0;
    tick();
    chk("hold count2", 64'(count_o), 64'd1);
    drain_vec(3, "hold");
    chk("hold empty", 64'(count_o), 64'd0);

    // Overflow: five captures into a depth-4 FIFO with ready low.
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      capture(i);
      tick();
    end
    chk("ovf count", 64'(count_o), 64'd4);
    chk("ovf flag",  64'(overflow_o), 64'd1);
    chk("ovf busy",  64'(busy_o), 64'd1);
    for (int i = 0; i < 4; i++) drain_vec(i, $sformatf("ovf%0d", i));
    chk("ovf empty", 64'(count_o), 64'd0);
    chk("ovf idle",  64'(out_valid_o), 64'd0);
    chk("ovf sticky", 64'(overflow_o), 64'd1);

    // Reset after lane 1 of a vector.
    out_ready_i = 1'b1;
    capture(1);
    tick(); tick();
    chk("mid lane", 64'(out_lane_o), 64'd2);
    rstn = 1'b0;
    tick();
    chk("mid rst valid", 64'(out_valid_o), 64'd0);
    chk("mid rst count", 64'(count_o), 64'd0);
    chk("mid rst ovf",   64'(overflow_o), 64'd0);
    chk("mid rst data",  64'(out_data_o), 64'd0);
    chk("mid rst lane",  64'(out_lane_o), 64'd0);
    rstn = 1'b1;
    tick();
    chk("mid no partial", 64'(out_valid_o), 64'd0);
    capture(2);
    drain_vec(2, "mid after");

    // Full FIFO, capture on the same edge as a last-lane pop.
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      capture(i);
      tick();
    end
    chk("fp count", 64'(count_o), 64'd4);
    out_ready_i = 1'b1;
    tick(); tick(); tick();
    chk("fp lane3", 64'(out_lane_o), 64'd3);
    chk("fp last",  64'(out_last_o), 64'd1);
    capture(4);
    chk("fp count after", 64'(count_o), 64'd4);
    chk("fp ovf",  64'(overflow_o), 64'd0);
    for (int i = 1; i < 5; i++) drain_vec(i, $sformatf("fp%0d", i));
    chk("fp empty", 64'(count_o), 64'd0);
    chk("fp idle",  64'(out_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ffn_result_drain

`default_nettype wire
